// File: rtl/sine_pwm_pkg.sv
// sine_pwm_pkg: shared definitions for the sine PWM generator.
//   PWM_BITS_DEFAULT / LUT_ADDR_BITS_DEFAULT : default carrier and phase widths
//   sample_t                                 : unsigned 8-bit sine table sample
//   LUT_MID / LUT_MAX / LUT_MIN              : table midpoint, peak and trough
`timescale 1ns/1ps
package sine_pwm_pkg;

  localparam int PWM_BITS_DEFAULT      = 8;
  localparam int LUT_ADDR_BITS_DEFAULT = 8;

  typedef logic [7:0] sample_t;

  localparam sample_t LUT_MID = 8'd128;
  localparam sample_t LUT_MAX = 8'd255;
  localparam sample_t LUT_MIN = 8'd1;

endpackage

// File: rtl/sine_lut.sv
// sine_lut: combinational constant ROM, one full sine period in 256 samples,
// lut[k] = round(128 + 127*sin(2*pi*k/256)), values 1..255.
//   phase  (in)  : table address
//   sample (out) : unsigned sample for that address
`timescale 1ns/1ps
module sine_lut
  import sine_pwm_pkg::*;
#(
  parameter int LUT_ADDR_BITS = LUT_ADDR_BITS_DEFAULT
) (
  input  logic [LUT_ADDR_BITS-1:0] phase,
  output logic [7:0]               sample
);

  // Full table (no quarter-wave folding) so the lookup is a single mux level.
  localparam sample_t ROM [0:255] = '{
    8'd128, 8'd131, 8'd134, 8'd137, 8'd140, 8'd144, 8'd147, 8'd150,
    8'd153, 8'd156, 8'd159, 8'd162, 8'd165, 8'd168, 8'd171, 8'd174,
    8'd177, 8'd179, 8'd182, 8'd185, 8'd188, 8'd191, 8'd193, 8'd196,
    8'd199, 8'd201, 8'd204, 8'd206, 8'd209, 8'd211, 8'd213, 8'd216,
    8'd218, 8'd220, 8'd222, 8'd224, 8'd226, 8'd228, 8'd230, 8'd232,
    8'd234, 8'd235, 8'd237, 8'd239, 8'd240, 8'd241, 8'd243, 8'd244,
    8'd245, 8'd246, 8'd248, 8'd249, 8'd250, 8'd250, 8'd251, 8'd252,
    8'd253, 8'd253, 8'd254, 8'd254, 8'd254, 8'd255, 8'd255, 8'd255,
    8'd255, 8'd255, 8'd255, 8'd255, 8'd254, 8'd254, 8'd254, 8'd253,
    8'd253, 8'd252, 8'd251, 8'd250, 8'd250, 8'd249, 8'd248, 8'd246,
    8'd245, 8'd244, 8'd243, 8'd241, 8'd240, 8'd239, 8'd237, 8'd235,
    8'd234, 8'd232, 8'd230, 8'd228, 8'd226, 8'd224, 8'd222, 8'd220,
    8'd218, 8'd216, 8'd213, 8'd211, 8'd209, 8'd206, 8'd204, 8'd201,
    8'd199, 8'd196, 8'd193, 8'd191, 8'd188, 8'd185, 8'd182, 8'd179,
    8'd177, 8'd174, 8'd171, 8'd168, 8'd165, 8'd162, 8'd159, 8'd156,
    8'd153, 8'd150, 8'd147, 8'd144, 8'd140, 8'd137, 8'd134, 8'd131,
    8'd128, 8'd125, 8'd122, 8'd119, 8'd116, 8'd112, 8'd109, 8'd106,
    8'd103, 8'd100, 8'd97,  8'd94,  8'd91,  8'd88,  8'd85,  8'd82,
    8'd79,  8'd77,  8'd74,  8'd71,  8'd68,  8'd65,  8'd63,  8'd60,
    8'd57,  8'd55,  8'd52,  8'd50,  8'd47,  8'd45,  8'd43,  8'd40,
    8'd38,  8'd36,  8'd34,  8'd32,  8'd30,  8'd28,  8'd26,  8'd24,
    8'd22,  8'd21,  8'd19,  8'd17,  8'd16,  8'd15,  8'd13,  8'd12,
    8'd11,  8'd10,  8'd8,   8'd7,   8'd6,   8'd6,   8'd5,   8'd4,
    8'd3,   8'd3,   8'd2,   8'd2,   8'd2,   8'd1,   8'd1,   8'd1,
    8'd1,   8'd1,   8'd1,   8'd1,   8'd2,   8'd2,   8'd2,   8'd3,
    8'd3,   8'd4,   8'd5,   8'd6,   8'd6,   8'd7,   8'd8,   8'd10,
    8'd11,  8'd12,  8'd13,  8'd15,  8'd16,  8'd17,  8'd19,  8'd21,
    8'd22,  8'd24,  8'd26,  8'd28,  8'd30,  8'd32,  8'd34,  8'd36,
    8'd38,  8'd40,  8'd43,  8'd45,  8'd47,  8'd50,  8'd52,  8'd55,
    8'd57,  8'd60,  8'd63,  8'd65,  8'd68,  8'd71,  8'd74,  8'd77,
    8'd79,  8'd82,  8'd85,  8'd88,  8'd91,  8'd94,  8'd97,  8'd100,
    8'd103, 8'd106, 8'd109, 8'd112, 8'd116, 8'd119, 8'd122, 8'd125
  };

  assign sample = ROM[phase];

endmodule

// File: rtl/sine_pwm.sv
// sine_pwm: PWM bit stream whose low-pass average follows a sine wave.
// Each table sample is held for one 2^PWM_BITS-clock carrier period; the
// output is high for lut[phase] clocks of that period.
//   clk_100 (in)  : 100 MHz clock, rising edge
//   rst_n   (in)  : asynchronous active-low reset, clears counters and output
//   en      (in)  : synchronous run enable; low pauses counters, forces sine=0
//   sine    (out) : registered PWM output
`timescale 1ns/1ps
module sine_pwm
  import sine_pwm_pkg::*;
#(
  parameter int PWM_BITS      = PWM_BITS_DEFAULT,
  parameter int LUT_ADDR_BITS = LUT_ADDR_BITS_DEFAULT
) (
  input  logic clk_100,
  input  logic rst_n,
  input  logic en,
  output logic sine
);

  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  logic [PWM_BITS-1:0]      pwm_cnt;
  logic [LUT_ADDR_BITS-1:0] phase;
  sample_t                  lut_sample;

  // Unsigned carrier compare; a sample never reaches 0 or 2^PWM_BITS so the
  // duty stays strictly between 0 % and 100 %.
  function automatic logic pwm_high(input logic [PWM_BITS-1:0] cnt,
                                    input sample_t             smp);
    return cnt < PWM_BITS'(smp);
  endfunction

  sine_lut #(
    .LUT_ADDR_BITS(LUT_ADDR_BITS)
  ) u_lut (
    .phase (phase),
    .sample(lut_sample)
  );

  // Stage 0: carrier and phase counters, frozen while en is low
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      phase   <= '0;
    end else if (en) begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (pwm_cnt == CNT_MAX) begin
        phase <= phase + LUT_ADDR_BITS'(1);
      end
    end
  end

  // Stage 1: output register, compares the pre-increment counter state
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      sine <= 1'b0;
    end else begin
      sine <= en & pwm_high(pwm_cnt, lut_sample);
    end
  end

endmodule

// File: tb/tb_sine_pwm.sv
`timescale 1ns/1ps
module tb_sine_pwm;

  logic clk_100 = 1'b0;
  logic rst_n   = 1'b0;
  logic en      = 1'b0;
  logic sine;

  always #5 clk_100 = ~clk_100;

  sine_pwm dut (
    .clk_100(clk_100),
    .rst_n  (rst_n),
    .en     (en),
    .sine   (sine)
  );

  int total = 0;
  int bad   = 0;

  int lut_m [256];
  int m_cnt   = 0;
  int m_phase = 0;
  int seq_err = 0;
  int dis_err = 0;

  int  win_hi [256];
  int  total_hi = 0;
  bit  win_on   = 1'b0;
  bit  per_on   = 1'b0;
  int  prev_ph  = 0;
  int  n_p1     = 0;
  realtime t_p1 [2];
  realtime edge_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: predict the registered output from the pre-edge model state,
  // advance the model, then sample the DUT mid-cycle.
  task automatic tick();
    logic e;
    int   ph;
    @(posedge clk_100);
    edge_t = $realtime;
    e  = en ? logic'(m_cnt < lut_m[m_phase]) : 1'b0;
    ph = m_phase;
    if (en) begin
      if (m_cnt == 255) m_phase = (m_phase + 1) % 256;
      m_cnt = (m_cnt + 1) % 256;
    end
    @(negedge clk_100);
    if (sine !== e) seq_err++;
    if (!en && sine !== 1'b0) dis_err++;
    if (win_on && en && sine === 1'b1) begin
      win_hi[ph]++;
      total_hi++;
    end
    if (per_on) begin
      if (int'(dut.phase) == 1 && prev_ph == 0 && n_p1 < 2) begin
        t_p1[n_p1] = edge_t;
        n_p1++;
      end
      prev_ph = int'(dut.phase);
    end
  endtask

  initial begin
    #1200us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p_hold, c_hold, wbad, lut_sum;
    lut_sum = 0;
    for (int k = 0; k < 256; k++) begin
      lut_m[k]  = $rtoi(128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 256.0) + 0.5);
      lut_sum  += lut_m[k];
      win_hi[k] = 0;
    end

    // Reset held with en=1
    rst_n = 1'b0;
    en    = 1'b1;
    repeat (3) @(posedge clk_100);
    @(negedge clk_100);
    check("rst_sine",  32'(sine), 0);
    check("rst_cnt",   32'(dut.pwm_cnt), 0);
    check("rst_phase", 32'(dut.phase), 0);

    // Pause/resume: idle to 70 us, then 3000 on / 3000 off / 3000 on
    en     = 1'b0;
    rst_n  = 1'b1;
    win_on = 1'b1;
    for (int i = 0; i < 8000 && $realtime < 70000.0; i++) tick();
    en = 1'b1;
    repeat (3000) tick();
    en = 1'b0;
    repeat (3000) tick();
    check("gap_hold_phase", 32'(dut.phase), 11);
    check("gap_hold_cnt",   32'(dut.pwm_cnt), 184);
    en = 1'b1;
    repeat (3000) tick();
    en = 1'b0;
    tick();
    check("resume_phase", 32'(dut.phase), 23);
    check("resume_cnt",   32'(dut.pwm_cnt), 112);
    check("first_window_hi", 32'(win_hi[0]), 128);
    check("disabled_high", 32'(dis_err), 0);

    // Run on to phase 100, then a 3 ns reset pulse between edges
    en = 1'b1;
    for (int i = 0; i < 30000 && !(m_phase == 100 && m_cnt == 10); i++) tick();
    check("p100_phase", 32'(dut.phase), 100);
    check("pre_reset_sine", 32'(sine), 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_sine",  32'(sine), 0);
    check("async_cnt",   32'(dut.pwm_cnt), 0);
    check("async_phase", 32'(dut.phase), 0);
    #2 rst_n = 1'b1;
    m_cnt   = 0;
    m_phase = 0;
    check("seq_before_reset", 32'(seq_err), 0);

    // Full sine period after the restart
    for (int k = 0; k < 256; k++) win_hi[k] = 0;
    total_hi = 0;
    per_on   = 1'b1;
    prev_ph  = 0;
    repeat (65536) tick();
    win_on = 1'b0;
    check("period_phase", 32'(dut.phase), 0);
    check("period_cnt",   32'(dut.pwm_cnt), 0);
    check("win0_hi",   32'(win_hi[0]),   128);
    check("win64_hi",  32'(win_hi[64]),  255);
    check("win128_hi", 32'(win_hi[128]), 128);
    check("win192_hi", 32'(win_hi[192]), 1);
    check("period_total_hi", 32'(total_hi), 32'(lut_sum));
    wbad = 0;
    for (int k = 0; k < 256; k++) if (win_hi[k] != lut_m[k]) wbad++;
    check("window_mismatches", 32'(wbad), 0);
    repeat (256) tick();
    check("period_edges_seen", 32'(n_p1), 2);
    if (n_p1 == 2) check("sine_period_ns", 32'($rtoi(t_p1[1] - t_p1[0] + 0.5)), 655360);

    // Enable edges around a high output
    repeat (3) tick();
    check("en_before_sine", 32'(sine), 1);
    en = 1'b0;
    tick();
    check("en_fall_sine", 32'(sine), 0);
    check("en_fall_hold", 32'(dut.pwm_cnt), 3);
    p_hold = int'(dut.phase);
    c_hold = int'(dut.pwm_cnt);
    tick();
    check("en_idle_phase", 32'(dut.phase), 32'(p_hold));
    check("en_idle_cnt",   32'(dut.pwm_cnt), 32'(c_hold));
    en = 1'b1;
    tick();
    check("en_rise_sine", 32'(sine), 1);
    check("en_rise_cnt",  32'(dut.pwm_cnt), 4);

    check("seq_mismatches", 32'(seq_err), 0);
    check("disabled_high_final", 32'(dis_err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
